// File: rtl/seq_booth_mult.sv
// Sequential add-shift multiplier, signed or unsigned, WIDTH x WIDTH -> 2*WIDTH.
// An X:A:B shift register retires one multiplier bit per clock through a
// (WIDTH+1)-bit adder/subtractor. In signed mode the last partial product is
// subtracted, which is what makes the multiplier's sign bit carry weight -2^(WIDTH-1).
//
// Handshake: Start is a level request that is accepted on any rising edge where
// the block is IDLE (Busy low). The operands and Signed_mode are captured on
// that same edge. Start, the operands and the mode are ignored while Busy is
// high. Done pulses for one cycle when Product becomes valid. Product then holds
// until the next accepted Start produces a new result.
module seq_booth_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Signed_mode,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 X,
  output logic [1:0]           state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             state_q;
  logic               x_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   s_q;
  logic               mode_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] product_q;
  logic               done_q;

  logic [WIDTH:0]     s_ext;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     r_sum;
  logic               last_iter;

  // One iteration of the partial-product datapath. In signed mode the top
  // multiplier bit has negative weight, so its partial product is subtracted.
  always_comb begin
    s_ext     = mode_q ? {s_q[WIDTH-1], s_q} : {1'b0, s_q};
    a_ext     = mode_q ? {x_q, a_q} : {1'b0, a_q};
    last_iter = (cnt_q == LAST_ITER);
    r_sum     = a_ext;
    if (b_q[0]) begin
      if (mode_q && last_iter) begin
        r_sum = a_ext - s_ext;
      end else begin
        r_sum = a_ext + s_ext;
      end
    end
  end

  // Control FSM and the X:A:B shift register, with registered Product and Done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      x_q       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            s_q     <= Multiplicand;
            b_q     <= Multiplier;
            mode_q  <= Signed_mode;
            a_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          // Signed: X duplicates the sign bit of R. Unsigned: the carry in R
          // moves into A's MSB and X stays 0.
          x_q   <= mode_q ? r_sum[WIDTH] : 1'b0;
          a_q   <= r_sum[WIDTH:1];
          b_q   <= {r_sum[0], b_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          product_q <= {a_q, b_q};
          done_q    <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Busy is decoded directly from the state register, so reset clears it immediately.
  always_comb begin
    Busy      = (state_q != ST_IDLE);
    Done      = done_q;
    Product   = product_q;
    X         = x_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Bench for seq_booth_mult. It runs an 8-bit instance through directed cases,
// a mid-operation reset and a back-to-back run. It runs a 16-bit instance
// through random signed and unsigned pairs. Products are compared against
// plain integer multiplication.
module tb_seq_booth_mult;

  logic clk;
  logic rst_n;

  logic        start8, sm8, busy8, done8, x8;
  logic [7:0]  mc8, mp8;
  logic [15:0] prod8;
  logic [1:0]  st8;

  logic        start16, sm16, busy16, done16, x16;
  logic [15:0] mc16, mp16;
  logic [31:0] prod16;
  logic [1:0]  st16;

  int checks;
  int errors;

  seq_booth_mult #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset_n(rst_n), .Start(start8), .Signed_mode(sm8),
    .Multiplicand(mc8), .Multiplier(mp8), .Busy(busy8), .Done(done8),
    .Product(prod8), .X(x8), .state_dbg(st8)
  );

  seq_booth_mult #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset_n(rst_n), .Start(start16), .Signed_mode(sm16),
    .Multiplicand(mc16), .Multiplier(mp16), .Busy(busy16), .Done(done16),
    .Product(prod16), .X(x16), .state_dbg(st16)
  );

  // Clock and a hard watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference model: exact integer product of the operands, truncated to 2*WIDTH bits.
  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    longint pa, pb, p;
    pa = sm ? longint'($signed(a)) : longint'(a);
    pb = sm ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    return p[15:0];
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic sm);
    longint pa, pb, p;
    pa = sm ? longint'($signed(a)) : longint'(a);
    pb = sm ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    return p[31:0];
  endfunction

  // One 8-bit multiply. Junk is driven on Start, the operands and the mode
  // while the operation runs.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm, input string name);
    logic [15:0] exp;
    int n;
    exp = ref8(a, b, sm);
    mc8 = a; mp8 = b; sm8 = sm; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    mc8 = 8'($urandom); mp8 = 8'($urandom); sm8 = 1'($urandom);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: busy=%b expected 1", name, busy8);
    end
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      start8 = 1'($urandom);
      @(posedge clk); #1;
      n++;
      mc8 = 8'($urandom); mp8 = 8'($urandom); sm8 = 1'($urandom);
    end
    start8 = 1'b0;
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected 9", name, n);
    end
    checks++;
    if (prod8 !== exp) begin
      errors++;
      $display("FAIL %s product: got %h expected %h", name, prod8, exp);
    end
    checks++;
    if (x8 !== (sm ? exp[15] : 1'b0)) begin
      errors++;
      $display("FAIL %s x: got %b expected %b", name, x8, (sm ? exp[15] : 1'b0));
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || prod8 !== exp) begin
      errors++;
      $display("FAIL %s hold: done=%b product=%h expected done=0 product=%h", name, done8, prod8, exp);
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm);
    logic [31:0] exp;
    int n;
    exp = ref16(a, b, sm);
    mc16 = a; mp16 = b; sm16 = sm; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    n = 0;
    while (done16 !== 1'b1 && n < 60) begin
      mc16 = 16'($urandom); mp16 = 16'($urandom); sm16 = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL w16 latency: got %0d cycles expected 17 (a=%h b=%h s=%b)", n, a, b, sm);
    end
    checks++;
    if (prod16 !== exp || x16 !== (sm ? exp[31] : 1'b0)) begin
      errors++;
      $display("FAIL w16 product: got %h x=%b expected %h x=%b (a=%h b=%h s=%b)",
               prod16, x16, exp, (sm ? exp[31] : 1'b0), a, b, sm);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; mc8 = '0; mp8 = '0;
    start16 = 1'b0; sm16 = 1'b0; mc16 = '0; mp16 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0 || x8 !== 1'b0 || st8 !== 2'd0) begin
      errors++;
      $display("FAIL reset w8: busy=%b done=%b product=%h x=%b state=%0d expected all 0",
               busy8, done8, prod8, x8, st8);
    end
    checks++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || prod16 !== 32'h0 || x16 !== 1'b0 || st16 !== 2'd0) begin
      errors++;
      $display("FAIL reset w16: busy=%b done=%b product=%h x=%b state=%0d expected all 0",
               busy16, done16, prod16, x16, st16);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed_w8();
    run8(8'h07, 8'hFD, 1'b1, "s_7x-3");
    run8(8'h07, 8'hFD, 1'b0, "u_7x253");
    run8(8'hFF, 8'hFF, 1'b0, "u_ffxff");
    run8(8'h80, 8'h80, 1'b1, "s_80x80");
    run8(8'hFF, 8'hFF, 1'b1, "s_ffxff");
    run8(8'h7F, 8'h80, 1'b1, "s_7fx80");
    run8(8'h00, 8'hA5, 1'b1, "s_zero");
  endtask

  task automatic test_reset_mid_op();
    run8(8'h7F, 8'h80, 1'b1, "pre_reset");
    mc8 = 8'h55; mp8 = 8'h33; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0 || x8 !== 1'b0 || st8 !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset async: busy=%b done=%b product=%h x=%b state=%0d expected all 0",
               busy8, done8, prod8, x8, st8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run8(8'hC3, 8'h5A, 1'b1, "post_reset_s");
    run8(8'hC3, 8'h5A, 1'b0, "post_reset_u");
  endtask

  // Start stays high. Results are scoreboarded, and the Done spacing and
  // the idle gap between operations are checked.
  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [15:0] exp;
    logic [7:0]  a, b;
    logic        sm, running;
    int cyc, last_done, low_run, n_done;
    a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
    mc8 = a; mp8 = b; sm8 = sm;
    exp_q.push_back(ref8(a, b, sm));
    start8 = 1'b1;
    running = 1'b1;
    cyc = 0; last_done = -1; low_run = 0; n_done = 0;
    while (cyc < 80 && (running || exp_q.size() != 0)) begin
      @(posedge clk); #1;
      cyc++;
      if (done8 === 1'b1) begin
        n_done++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          exp = exp_q.pop_front();
          if (prod8 !== exp) begin
            errors++;
            $display("FAIL b2b product: got %h expected %h", prod8, exp);
          end
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done !== 10) begin
            errors++;
            $display("FAIL b2b done_period: got %0d expected 10", cyc - last_done);
          end
        end
        last_done = cyc;
      end
      if (busy8 === 1'b0) begin
        low_run++;
      end else begin
        if (low_run > 0) begin
          checks++;
          if (low_run !== 1) begin
            errors++;
            $display("FAIL b2b busy_gap: got %0d idle cycles expected 1", low_run);
          end
        end
        low_run = 0;
      end
      if (running && cyc >= 30 && busy8 === 1'b1) begin
        start8 = 1'b0;
        running = 1'b0;
      end
      if (busy8 === 1'b0 && running) begin
        a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
        mc8 = a; mp8 = b; sm8 = sm;
        exp_q.push_back(ref8(a, b, sm));
      end else begin
        mc8 = 8'($urandom); mp8 = 8'($urandom); sm8 = 1'($urandom);
      end
    end
    start8 = 1'b0;
    checks++;
    if (exp_q.size() != 0 || n_done < 3) begin
      errors++;
      $display("FAIL b2b drain: got %0d pending %0d done expected 0 pending at least 3 done",
               exp_q.size(), n_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_w16();
    for (int i = 0; i < 1000; i++) begin
      run16(16'($urandom), 16'($urandom), 1'b0);
    end
    for (int i = 0; i < 1000; i++) begin
      run16(16'($urandom), 16'($urandom), 1'b1);
    end
    run16(16'h8000, 16'h8000, 1'b1);
    run16(16'hFFFF, 16'hFFFF, 1'b0);
    run16(16'h7FFF, 16'h8000, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed_w8();
    test_reset_mid_op();
    test_back_to_back();
    test_random_w16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_booth_mult.md
Name: seq_booth_mult

Overview:
- Parametrised sequential add-shift multiplier. It is the next generation of the 8-bit lab multiplier datapath.
- Operand width, signed/unsigned mode and a start/busy/done handshake are all configurable or selectable.
- Internally it keeps an X:A:B shift register. It uses a (WIDTH+1)-bit adder/subtractor and retires one multiplier bit per clock.
- It sits between the switch/register front end and the hex-display back end, and produces a 2*WIDTH-bit product.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter. Derived; not overridden.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  request to start a multiply. Level-sampled in IDLE only.
- Signed_mode  in  1  1 = two's-complement operands, 0 = unsigned. Sampled with Start.
- Multiplicand  in  WIDTH  S operand. Sampled with Start.
- Multiplier  in  WIDTH  B operand. Sampled with Start.
- Busy  out  1  high while in COMPUTE or DONE.
- Done  out  1  one-cycle pulse when Product becomes valid.
- Product  out  2*WIDTH  {A,B} result. Held until the next accepted Start.
- X  out  1  sign/carry extension bit of A.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State=IDLE.
  - X, A, B, S, counter, Product, Busy and Done all 0.
  - Takes effect mid-operation; the partial result is discarded.
- States: IDLE, COMPUTE, DONE.
- IDLE, Start=1 on a clock edge:
  - Latch S<=Multiplicand, B<=Multiplier, mode<=Signed_mode.
  - Clear A and X; counter<=0.
  - Go to COMPUTE.
- COMPUTE, each cycle (iteration i = counter):
  - Extend S to WIDTH+1 bits: Sext={S[WIDTH-1],S} if signed, else {1'b0,S}.
  - Extend A the same way: Aext={X,A} if signed, else {1'b0,A}.
  - If B[0]=1:
    - Signed mode and i=WIDTH-1: R=Aext-Sext.
    - Otherwise: R=Aext+Sext.
  - If B[0]=0: R=Aext.
  - Shift {R,B} right by one as a (2*WIDTH+1)-bit quantity:
    - Signed mode: the new X is R[WIDTH], duplicated.
    - Unsigned mode: R[WIDTH] is the carry. It shifts into A's MSB, and the new X is 0.
  - counter<=counter+1. When counter reaches WIDTH-1, go to DONE next.
- COMPUTE latency: exactly WIDTH cycles.
- DONE (one cycle):
  - Product<={A,B} registered; Done=1.
  - Go to IDLE unconditionally.
  - Start is ignored in this cycle.
- Timing: Done is asserted WIDTH+1 cycles after the Start-accept edge. Product is valid from the Done cycle onward.
- Start behaviour:
  - Start held high continuously re-triggers from IDLE. Back-to-back operations have a period of WIDTH+2 cycles.
  - Start during COMPUTE or DONE has no effect.
  - Operand and mode changes during COMPUTE are ignored.
- Busy = (state != IDLE), decoded combinationally from the state register.
- Arithmetic rules:
  - The adder is WIDTH+1 bits. Overflow beyond WIDTH+1 bits cannot occur, including the most-negative × most-negative case.
  - Signed results are exact two's-complement 2*WIDTH-bit values.
  - Unsigned results are exact 2*WIDTH-bit values.
- Zero operands: no special fast path; the full WIDTH cycles always run.
- X is observable during COMPUTE for debug. X=0 after an unsigned operation.

Test Plan:
- WIDTH=8, signed, 0x07 × 0xFD (7 × -3): Done exactly 9 cycles after accept, Product=0xFFEB, X=1.
- WIDTH=8, unsigned, 0x07 × 0xFD: Product=0x06EB, X=0. Then 0xFF × 0xFF: Product=0xFE01.
- WIDTH=8, signed corner cases:
  - 0x80 × 0x80: Product=0x4000.
  - 0xFF × 0xFF: Product=0x0001.
  - 0x7F × 0x80: Product=0xC080.
- Reset_n pulsed low at counter=4 mid-COMPUTE:
  - Outputs are 0 immediately, without waiting for a clock edge.
  - State=IDLE; a following multiply gives the correct result.
- Start held high for 30 cycles:
  - Done pulses every 10 cycles.
  - Operand changes mid-COMPUTE do not alter Product.
  - Busy is low for exactly one cycle between operations.
- WIDTH=16, random signed and unsigned pairs (≥1000 each), checked against the $signed and $unsigned reference product. Latency = 17 cycles.
